// File: rtl/ls163_video_timing.sv
// Raster H/V counter chain built from cascaded LS163-style synchronous counter stages,
// with registered blank/sync flags and line/frame start pulses.

module ls163_video_timing_stage #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic [W-1:0] q_nxt
);

  // Synchronous clear wins over enable, as on the LS163 CLR pin.
  always_comb begin
    q_nxt = q;
    if (clr)
      q_nxt = '0;
    else if (en)
      q_nxt = q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else
      q <= q_nxt;
  end

endmodule

module ls163_video_timing #(
  parameter int H_TOTAL       = 384,
  parameter int H_BLANK_START = 256,
  parameter int H_SYNC_START  = 304,
  parameter int H_SYNC_END    = 336,
  parameter int V_TOTAL       = 264,
  parameter int V_BLANK_START = 240,
  parameter int V_BLANK_END   = 16,
  parameter int V_SYNC_START  = 244,
  parameter int V_SYNC_END    = 248
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cen,
  input  logic       sync_clr,
  output logic [8:0] h_cnt,
  output logic [8:0] v_cnt,
  output logic       hblank,
  output logic       vblank,
  output logic       hsync,
  output logic       vsync,
  output logic       h_tc,
  output logic       line_start,
  output logic       frame_start
);

  if (H_TOTAL < 2 || H_TOTAL > 512 || V_TOTAL < 2 || V_TOTAL > 512) begin : g_bad_total
    $error("ls163_video_timing: H_TOTAL/V_TOTAL must lie in 2..512");
  end

  if (H_BLANK_START > 511 || H_SYNC_START > 511 || H_SYNC_END > 511 ||
      V_BLANK_START > 511 || V_BLANK_END > 511 || V_SYNC_START > 511 ||
      V_SYNC_END > 511 || H_BLANK_START < 0 || H_SYNC_START < 0 ||
      H_SYNC_END < 0 || V_BLANK_START < 0 || V_BLANK_END < 0 ||
      V_SYNC_START < 0 || V_SYNC_END < 0) begin : g_bad_edge
    $error("ls163_video_timing: timing edges must lie in 0..511");
  end

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_BS   = 9'(H_BLANK_START);
  localparam logic [8:0] H_SS   = 9'(H_SYNC_START);
  localparam logic [8:0] H_SE   = 9'(H_SYNC_END);
  localparam logic [8:0] V_BS   = 9'(V_BLANK_START);
  localparam logic [8:0] V_BE   = 9'(V_BLANK_END);
  localparam logic [8:0] V_SS   = 9'(V_SYNC_START);
  localparam logic [8:0] V_SE   = 9'(V_SYNC_END);

  logic [3:0] h_q0, h_q1, h_n0, h_n1;
  logic [0:0] h_q2, h_n2;
  logic [3:0] v_q0, v_q1, v_n0, v_n1;
  logic [0:0] v_q2, v_n2;

  logic [8:0] h_nxt;
  logic [8:0] v_nxt;
  logic       h_at_last;
  logic       v_at_last;
  logic       h_clr;
  logic       v_clr;
  logic       h_en0, h_en1, h_en2;
  logic       v_en0, v_en1, v_en2;

  assign h_cnt = {h_q2, h_q1, h_q0};
  assign v_cnt = {v_q2, v_q1, v_q0};
  assign h_nxt = {h_n2, h_n1, h_n0};
  assign v_nxt = {v_n2, v_n1, v_n0};

  assign h_at_last = (h_cnt == H_LAST);
  assign v_at_last = (v_cnt == V_LAST);

  // Ripple carry: each stage's RCO feeds the next stage's ENT, all qualified by cen.
  assign h_tc  = h_at_last & cen;
  assign h_en0 = cen;
  assign h_en1 = h_en0 & (h_q0 == 4'hF);
  assign h_en2 = h_en1 & (h_q1 == 4'hF);
  assign h_clr = sync_clr | h_tc;

  assign v_en0 = h_tc;
  assign v_en1 = v_en0 & (v_q0 == 4'hF);
  assign v_en2 = v_en1 & (v_q1 == 4'hF);
  assign v_clr = sync_clr | (h_tc & v_at_last);

  ls163_video_timing_stage #(.W(4)) u_h0 (
    .clk(clk), .reset(reset), .en(h_en0), .clr(h_clr), .q(h_q0), .q_nxt(h_n0)
  );
  ls163_video_timing_stage #(.W(4)) u_h1 (
    .clk(clk), .reset(reset), .en(h_en1), .clr(h_clr), .q(h_q1), .q_nxt(h_n1)
  );
  ls163_video_timing_stage #(.W(1)) u_h2 (
    .clk(clk), .reset(reset), .en(h_en2), .clr(h_clr), .q(h_q2), .q_nxt(h_n2)
  );

  ls163_video_timing_stage #(.W(4)) u_v0 (
    .clk(clk), .reset(reset), .en(v_en0), .clr(v_clr), .q(v_q0), .q_nxt(v_n0)
  );
  ls163_video_timing_stage #(.W(4)) u_v1 (
    .clk(clk), .reset(reset), .en(v_en1), .clr(v_clr), .q(v_q1), .q_nxt(v_n1)
  );
  ls163_video_timing_stage #(.W(1)) u_v2 (
    .clk(clk), .reset(reset), .en(v_en2), .clr(v_clr), .q(v_q2), .q_nxt(v_n2)
  );

  // Flags decode the next count so they line up with h_cnt/v_cnt in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hblank      <= 1'b0;
      vblank      <= 1'b1;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hblank      <= (h_nxt >= H_BS);
      vblank      <= (v_nxt >= V_BS) | (v_nxt < V_BE);
      hsync       <= (h_nxt >= H_SS) & (h_nxt < H_SE);
      vsync       <= (v_nxt >= V_SS) & (v_nxt < V_SE);
      line_start  <= sync_clr | h_tc;
      frame_start <= sync_clr | (h_tc & v_at_last);
    end
  end

endmodule

// File: tb/tb_ls163_video_timing.sv
// Directed bench for ls163_video_timing: default raster instance plus a shrunken raster
// instance so a whole frame wrap fits in a short run.

module tb_ls163_video_timing;

  logic clk = 1'b0;
  logic reset;
  logic cen;
  logic sync_clr;

  logic [8:0] a_h, a_v, b_h, b_v;
  logic a_hb, a_vb, a_hs, a_vs, a_tc, a_ls, a_fs;
  logic b_hb, b_vb, b_hs, b_vs, b_tc, b_ls, b_fs;

  int vectors = 0;
  int miscompares = 0;

  int ht[2]  = '{384, 24};
  int hbs[2] = '{256, 16};
  int hss[2] = '{304, 18};
  int hse[2] = '{336, 20};
  int vt[2]  = '{264, 20};
  int vbs[2] = '{240, 15};
  int vbe[2] = '{16, 2};
  int vss[2] = '{244, 16};
  int vse[2] = '{248, 18};

  int   hm[2];
  int   vm[2];
  logic lsm[2];
  logic fsm[2];

  always #5 clk = ~clk;

  ls163_video_timing dut_a (
    .clk(clk), .reset(reset), .cen(cen), .sync_clr(sync_clr),
    .h_cnt(a_h), .v_cnt(a_v), .hblank(a_hb), .vblank(a_vb),
    .hsync(a_hs), .vsync(a_vs), .h_tc(a_tc),
    .line_start(a_ls), .frame_start(a_fs)
  );

  ls163_video_timing #(
    .H_TOTAL(24), .H_BLANK_START(16), .H_SYNC_START(18), .H_SYNC_END(20),
    .V_TOTAL(20), .V_BLANK_START(15), .V_BLANK_END(2),
    .V_SYNC_START(16), .V_SYNC_END(18)
  ) dut_b (
    .clk(clk), .reset(reset), .cen(cen), .sync_clr(sync_clr),
    .h_cnt(b_h), .v_cnt(b_v), .hblank(b_hb), .vblank(b_vb),
    .hsync(b_hs), .vsync(b_vs), .h_tc(b_tc),
    .line_start(b_ls), .frame_start(b_fs)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hm[i] = 0; vm[i] = 0; lsm[i] = 1'b0; fsm[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic c, input logic s);
    for (int i = 0; i < 2; i++) begin
      if (s) begin
        hm[i] = 0; vm[i] = 0; lsm[i] = 1'b1; fsm[i] = 1'b1;
      end else if (c) begin
        lsm[i] = (hm[i] == ht[i] - 1);
        fsm[i] = lsm[i] && (vm[i] == vt[i] - 1);
        if (lsm[i]) begin
          hm[i] = 0;
          vm[i] = (vm[i] == vt[i] - 1) ? 0 : vm[i] + 1;
        end else begin
          hm[i] = hm[i] + 1;
        end
      end else begin
        lsm[i] = 1'b0; fsm[i] = 1'b0;
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [8:0] h, input logic [8:0] v,
                            input logic hb, input logic vb, input logic hs, input logic vs,
                            input logic tc, input logic ls, input logic fs);
    string n = (i == 0) ? "A" : "B";
    chk({n, " h_cnt"},       16'(h),  16'(hm[i]));
    chk({n, " v_cnt"},       16'(v),  16'(vm[i]));
    chk({n, " hblank"},      16'(hb), 16'(hm[i] >= hbs[i]));
    chk({n, " vblank"},      16'(vb), 16'(vm[i] >= vbs[i] || vm[i] < vbe[i]));
    chk({n, " hsync"},       16'(hs), 16'(hm[i] >= hss[i] && hm[i] < hse[i]));
    chk({n, " vsync"},       16'(vs), 16'(vm[i] >= vss[i] && vm[i] < vse[i]));
    chk({n, " h_tc"},        16'(tc), 16'(hm[i] == ht[i] - 1 && cen));
    chk({n, " line_start"},  16'(ls), 16'(lsm[i]));
    chk({n, " frame_start"}, 16'(fs), 16'(fsm[i]));
  endtask

  // Called at a falling edge; drives inputs, takes one rising edge, checks at the next falling edge.
  task automatic tick(input logic c, input logic s);
    cen = c;
    sync_clr = s;
    @(posedge clk);
    model_step(c, s);
    @(negedge clk);
    check_inst(0, a_h, a_v, a_hb, a_vb, a_hs, a_vs, a_tc, a_ls, a_fs);
    check_inst(1, b_h, b_v, b_hb, b_vb, b_hs, b_vs, b_tc, b_ls, b_fs);
  endtask

  task automatic run_to(input int i, input int h, input int v, input int budget);
    int n = 0;
    while (!(hm[i] == h && (v < 0 || vm[i] == v)) && n < budget) begin
      tick(1'b1, 1'b0);
      n++;
    end
    chk("run_to reach h", 16'((i == 0) ? a_h : b_h), 16'(h));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " h_cnt"},       16'(a_h),  16'd0);
    chk({tag, " v_cnt"},       16'(a_v),  16'd0);
    chk({tag, " hblank"},      16'(a_hb), 16'd0);
    chk({tag, " vblank"},      16'(a_vb), 16'd1);
    chk({tag, " hsync"},       16'(a_hs), 16'd0);
    chk({tag, " vsync"},       16'(a_vs), 16'd0);
    chk({tag, " line_start"},  16'(a_ls), 16'd0);
    chk({tag, " frame_start"}, 16'(a_fs), 16'd0);
    chk({tag, " B v_cnt"},     16'(b_v),  16'd0);
  endtask

  initial begin
    reset = 1'b1;
    cen = 1'b0;
    sync_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // First line at full rate.
    repeat (383) tick(1'b1, 1'b0);
    chk("line0 end h", 16'(a_h), 16'd383);
    chk("line0 end h_tc", 16'(a_tc), 16'd1);
    chk("line0 end v", 16'(a_v), 16'd0);
    tick(1'b1, 1'b0);
    chk("wrap h", 16'(a_h), 16'd0);
    chk("wrap v", 16'(a_v), 16'd1);
    chk("wrap line_start", 16'(a_ls), 16'd1);
    chk("wrap frame_start", 16'(a_fs), 16'd0);
    tick(1'b1, 1'b0);
    chk("after wrap h", 16'(a_h), 16'd1);
    chk("after wrap line_start", 16'(a_ls), 16'd0);

    // One line at 1-in-8 enable duty.
    for (int k = 0; k < 400 && hm[0] != 383; k++) begin
      tick(1'b1, 1'b0);
      repeat (7) tick(1'b0, 1'b0);
    end
    chk("slow end h", 16'(a_h), 16'd383);
    chk("slow idle h_tc", 16'(a_tc), 16'd0);
    cen = 1'b1;
    #1;
    chk("slow cen h_tc", 16'(a_tc), 16'd1);
    tick(1'b1, 1'b0);
    chk("slow wrap h", 16'(a_h), 16'd0);
    chk("slow wrap v", 16'(a_v), 16'd2);
    chk("slow wrap line_start", 16'(a_ls), 16'd1);
    tick(1'b0, 1'b0);
    chk("slow pulse width", 16'(a_ls), 16'd0);
    chk("slow hold h", 16'(a_h), 16'd0);

    // Horizontal flag edges.
    run_to(0, 255, -1, 500);
    chk("h255 hblank", 16'(a_hb), 16'd0);
    tick(1'b1, 1'b0);
    chk("h256 hblank", 16'(a_hb), 16'd1);
    run_to(0, 303, -1, 500);
    chk("h303 hsync", 16'(a_hs), 16'd0);
    tick(1'b1, 1'b0);
    chk("h304 hsync", 16'(a_hs), 16'd1);
    run_to(0, 335, -1, 500);
    chk("h335 hsync", 16'(a_hs), 16'd1);
    tick(1'b1, 1'b0);
    chk("h336 hsync", 16'(a_hs), 16'd0);
    run_to(0, 383, -1, 500);
    chk("h383 hblank", 16'(a_hb), 16'd1);
    tick(1'b1, 1'b0);
    chk("h0 hblank", 16'(a_hb), 16'd0);

    // Frame wrap and vertical flag edges on the small raster.
    run_to(1, 23, 19, 1000);
    chk("B last v", 16'(b_v), 16'd19);
    chk("B last vblank", 16'(b_vb), 16'd1);
    tick(1'b1, 1'b0);
    chk("B frame h", 16'(b_h), 16'd0);
    chk("B frame v", 16'(b_v), 16'd0);
    chk("B frame_start", 16'(b_fs), 16'd1);
    chk("B frame line_start", 16'(b_ls), 16'd1);
    tick(1'b1, 1'b0);
    chk("B frame_start width", 16'(b_fs), 16'd0);
    run_to(1, 23, 1, 1000);
    chk("B v1 vblank", 16'(b_vb), 16'd1);
    tick(1'b1, 1'b0);
    chk("B v2 vblank", 16'(b_vb), 16'd0);
    run_to(1, 0, 14, 1000);
    chk("B v14 vblank", 16'(b_vb), 16'd0);
    run_to(1, 0, 15, 1000);
    chk("B v15 vblank", 16'(b_vb), 16'd1);
    chk("B v15 vsync", 16'(b_vs), 16'd0);
    run_to(1, 0, 16, 1000);
    chk("B v16 vsync", 16'(b_vs), 16'd1);
    run_to(1, 23, 17, 1000);
    chk("B v17 vsync", 16'(b_vs), 16'd1);
    tick(1'b1, 1'b0);
    chk("B v18 vsync", 16'(b_vs), 16'd0);

    // Default raster: end of top blanking.
    run_to(0, 383, 15, 8000);
    chk("v15 vblank", 16'(a_vb), 16'd1);
    tick(1'b1, 1'b0);
    chk("v16 v", 16'(a_v), 16'd16);
    chk("v16 vblank", 16'(a_vb), 16'd0);

    // Synchronous clear with cen low.
    run_to(0, 100, 50, 20000);
    chk("pre clr v", 16'(a_v), 16'd50);
    tick(1'b0, 1'b1);
    chk("clr h", 16'(a_h), 16'd0);
    chk("clr v", 16'(a_v), 16'd0);
    chk("clr frame_start", 16'(a_fs), 16'd1);
    chk("clr line_start", 16'(a_ls), 16'd1);
    chk("clr vblank", 16'(a_vb), 16'd1);
    chk("clr hblank", 16'(a_hb), 16'd0);
    tick(1'b0, 1'b0);
    chk("clr pulse end", 16'(a_fs), 16'd0);

    // Asynchronous reset mid-frame.
    run_to(0, 200, 120, 50000);
    chk("pre rst v", 16'(a_v), 16'd120);
    chk("pre rst vblank", 16'(a_vb), 16'd0);
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("async rst");
    @(negedge clk);
    check_reset_values("rst held");
    reset = 1'b0;
    tick(1'b1, 1'b0);
    chk("post rst h", 16'(a_h), 16'd1);
    chk("post rst v", 16'(a_v), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ls163_video_timing.md
Name: ls163_video_timing

Overview:
- Horizontal/vertical raster counter chain modelled on cascaded 74LS163 synchronous 4-bit counters.
- Supplies the count bits that downstream 4-input NAND decode gates in the video section use for blanking and sync decode.
- Also produces pre-decoded blank/sync flags and line/frame pulses.
- Default timing is the 256x224 arcade raster: 384 pixel clocks per line, 264 lines per frame.

Parameters:
- H_TOTAL, 384, pixel clocks per line; h_cnt wraps at H_TOTAL-1.
- H_BLANK_START, 256, first blanked h_cnt; blank runs to H_TOTAL-1.
- H_SYNC_START, 304, first h_cnt with hsync asserted.
- H_SYNC_END, 336, first h_cnt with hsync deasserted.
- V_TOTAL, 264, lines per frame; v_cnt wraps at V_TOTAL-1.
- V_BLANK_START, 240, first blanked line.
- V_BLANK_END, 16, first unblanked line; vblank = (v_cnt >= V_BLANK_START) | (v_cnt < V_BLANK_END).
- V_SYNC_START, 244, first line with vsync asserted.
- V_SYNC_END, 248, first line with vsync deasserted.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- cen, input, 1, pixel clock enable; counting occurs only on clk edges with cen=1.
- sync_clr, input, 1, synchronous clear of both counters (LS163 CLR equivalent, active-high here).
- h_cnt, output, 9, horizontal count, registered.
- v_cnt, output, 9, vertical count, registered.
- hblank, output, 1, active-high horizontal blank.
- vblank, output, 1, active-high vertical blank.
- hsync, output, 1, active-high horizontal sync.
- vsync, output, 1, active-high vertical sync.
- h_tc, output, 1, horizontal terminal count (ripple carry), combinational: (h_cnt == H_TOTAL-1) & cen.
- line_start, output, 1, one-clk pulse on the edge where h_cnt becomes 0.
- frame_start, output, 1, one-clk pulse on the edge where h_cnt and v_cnt both become 0.

Behaviour:
- Reset (async, dominates everything):
  - h_cnt=0, v_cnt=0.
  - hblank=0, vblank=1, hsync=0, vsync=0.
  - line_start=0, frame_start=0.
- Counters are internally four-bit LS163-style stages. Stage n+1 enables when stage n carry is high; each carry is qualified by cen. Externally this is equivalent to a 9-bit synchronous binary count.
- Edge with cen=1, sync_clr=0:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only when h_cnt is at H_TOTAL-1; at V_TOTAL-1 it wraps to 0.
- Edge with sync_clr=1: h_cnt=0 and v_cnt=0 regardless of cen.
  - sync_clr has priority over counting.
  - Flags are recomputed for count (0,0).
  - line_start=1 and frame_start=1 on that edge.
- Edge with cen=0 and sync_clr=0: all registers hold; line_start and frame_start forced 0.
- Flag timing: hblank, vblank, hsync and vsync are registered from the next-count values, so they are always consistent with the h_cnt/v_cnt presented in the same cycle (zero relative latency).
  - hsync = (h_cnt >= H_SYNC_START) & (h_cnt < H_SYNC_END).
  - vsync uses the same form with the V_SYNC parameters.
- Pulses: line_start and frame_start are each high for exactly one clk, then cleared on the next edge.
- h_tc drops combinationally with cen, matching the LS163 RCO/ENT relation.
- Counts never exceed TOTAL-1, so no out-of-range values appear. Values beyond 511 are illegal parameters and are rejected at elaboration.
- Reset asserted mid-line: outputs go to reset values immediately. The first cen after release advances to h_cnt=1.

Test Plan:
- Reset release, cen tied 1 for 384 clks -> h_cnt steps 0..383 then 0. line_start pulses once, at the wrap edge. v_cnt goes 0->1 on that same edge.
- cen 1-in-8 duty -> h_cnt advances once per 8 clks. line_start and frame_start are one clk wide. h_tc is high only on the cen cycle at h_cnt=383.
- Run a full frame (384*264 cen) -> v_cnt wraps 263->0 with frame_start=1. Check flags at the boundaries:
  - vblank=1 at lines 240..263 and 0..15, 0 at line 16.
  - vsync=1 only at lines 244..247.
- Within one line, sample flags -> hblank rises at h=256 and falls at h=0. hsync=1 exactly at h=304..335.
- Assert sync_clr at h=100, v=50 with cen=0 -> next edge gives h=0, v=0, frame_start=1, vblank=1, hblank=0.
- Assert reset at h=200, v=120 between edges -> outputs reach reset values asynchronously, before the next clk. After release, counting resumes from 0.
